trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Trap sequencer between the ID/EX stage and the CSR register file. Accepts masked interrupt
//  flags (external/timer/software), synchronous exceptions (ecall/ebreak/illegal) and mret.
//  Drives the CSR trap write/read channel to save or restore mepc/mcause/mstatus.
//  Holds the pipeline during the sequence, then issues a one-cycle redirect to the handler or to mepc.
// PARAMETERS
//  RST_PC      32'h0   reserved; jump_addr_o reset value
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   reset, asynchronous, active-low
//  ex_trap_i         in   1   external irq, already masked by mie.MEIE
//  tcmp_trap_i       in   1   timer irq, already masked by mie.MTIE
//  soft_trap_i       in   1   software irq, already masked by mie.MSIE
//  mstatus_mie_i     in   1   global interrupt enable (mstatus.MIE)
//  mepc_i            in   32  current mepc, direct from CSR file
//  inst_valid_i      in   1   ID/EX holds a valid instruction at inst_pc_i
//  inst_pc_i         in   32  PC of instruction in ID/EX
//  ecall_i           in   1   ecall decoded; qualified by inst_valid_i
//  ebreak_i          in   1   ebreak decoded; qualified by inst_valid_i
//  illegal_i         in   1   illegal instruction; qualified by inst_valid_i
//  mret_i            in   1   mret decoded; qualified by inst_valid_i
//  trap_csr_we_o     out  1   CSR trap-channel write enable
//  trap_csr_addr_o   out  12  CSR trap-channel address; drives the combinational read
//  trap_csr_wdata_o  out  32  CSR trap-channel write data
//  trap_csr_rdata_i  in   32  CSR trap-channel read data, same-cycle
//  hold_o            out  1   stall fetch/ID/EX and suppress ID/EX CSR writes and writeback
//  jump_o            out  1   one-cycle redirect strobe
//  jump_addr_o       out  32  redirect target; valid while jump_o=1
// BEHAVIOUR
//  Reset: state=IDLE; we/hold/jump=0; addr/wdata=0; jump_addr=RST_PC.
//  States: IDLE, S_MEPC, S_MCAUSE, S_MSTAT, S_JUMP, S_MRET.
//  Accept rule, IDLE only, requires inst_valid_i:
//   - Priority: exception (illegal > ebreak > ecall) > mret > interrupt.
//   - Interrupt taken only if mstatus_mie_i=1; irq priority ext > soft > timer.
//  Accept cycle: latch cause and PC; hold_o=1 combinationally in the same cycle.
//   - Exception: the faulting instruction is not retired.
//   - Interrupt: the instruction at inst_pc_i is not executed.
//  mcause values: ext 0x8000000B; soft 0x80000003; timer 0x80000007;
//   ecall 0x0000000B; ebreak 0x00000003; illegal 0x00000002.
//  Trap entry, one CSR write per state:
//   S_MEPC: we=1, addr=0x341, wdata=latched PC.
//   S_MCAUSE: we=1, addr=0x342, wdata=cause.
//   S_MSTAT: read 0x300; write with bit7 (MPIE) = rdata[3], bit3 (MIE) = 0, other bits = rdata.
//   S_JUMP: addr=0x305; jump_o=1; jump_addr_o = {rdata[31:2],2'b00}; hold_o=1; next IDLE.
//   Timing: jump_o rises 4 cycles after the accept cycle.
//  mret: S_MRET reads 0x300 and writes bit3 = rdata[7], bit7 = 1.
//   Next S_JUMP with jump_addr_o = mepc_i. mepc_i is sampled in S_JUMP.
//  hold_o=1 from the accept cycle through S_JUMP inclusive. Because hold_o is high, ID/EX never
//   issues CSR writes during a sequence, so the ID/EX-over-trap write priority in the CSR file
//   never blocks trap writes.
//  Irq asserted mid-sequence: ignored and not latched. Re-evaluated in IDLE from the level.
//   Since MIE=0 after entry, a nested irq is not taken.
//  Irq and mret in the same cycle: mret wins. Irq is re-evaluated after the return.
//  Irq deasserted on the accept cycle: the sequence still completes with the latched cause.
//  Exception while MIE=0: still taken. Exceptions are never masked.
//  Reset mid-sequence: back to IDLE immediately with all outputs at reset values.
//   Partially written CSRs are not rolled back.
// CONFIGURATION
//  TRAP_VECTORED_EN defined:
//   - If the mtvec read in S_JUMP has rdata[1:0]==2'b01 and the cause is an interrupt:
//     jump_addr_o = {rdata[31:2],2'b00} + 4*cause[30:0].
//   - Exceptions always go to the base.
//  TRAP_VECTORED_EN undefined: direct mode only; rdata[1:0] ignored.
// STRUCTURE
//  Shared defines.v: CSR address macros (CSR_MEPC/MCAUSE/MSTATUS/MTVEC) and new
//   TRAP_CAUSE_* mcause constants. State encoding stays local.
//  One sub-module, trap_prio: combinational priority encoder.
//   Inputs: exception/mret/irq inputs plus MIE.
//   Outputs: take, is_mret, is_irq, cause[31:0].
// TESTING
//  1. mtvec=0x100, MIE=1, ex_trap_i pulse at PC 0x2000.
//     -> mepc=0x2000, mcause=0x8000000B, MIE=0, MPIE=1; jump to 0x100 four cycles after accept.
//  2. ecall at PC 0x40 with MIE=0 -> mcause=0xB, mepc=0x40, jump to the mtvec base.
//  3. mret with mepc=0x2000, MPIE=1 -> MIE=1, MPIE=1; jump_addr=0x2000 two cycles after accept.
//  4. ext+soft+timer asserted together -> cause 0x8000000B.
//     Then, still in the handler (MIE=0), timer stays high -> no second entry until mret.
//  5. rst_n low during S_MCAUSE -> outputs reset; FSM in IDLE the next cycle.
//  6. TRAP_VECTORED_EN, mtvec=0x101, timer irq -> jump to 0x11C. Undefined -> jump to 0x100.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses and mcause constants shared by the trap sequencer files.
package trap_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [31:0] TRAP_CAUSE_EXT     = 32'h8000_000B;
    localparam logic [31:0] TRAP_CAUSE_SOFT    = 32'h8000_0003;
    localparam logic [31:0] TRAP_CAUSE_TIMER   = 32'h8000_0007;
    localparam logic [31:0] TRAP_CAUSE_ECALL   = 32'h0000_000B;
    localparam logic [31:0] TRAP_CAUSE_EBREAK  = 32'h0000_0003;
    localparam logic [31:0] TRAP_CAUSE_ILLEGAL = 32'h0000_0002;

endpackage

// File: rtl/trap_prio.sv
// trap_prio: combinational priority encoder selecting which trap/mret to accept.
//  Inputs : valid_i (ID/EX valid), illegal_i/ebreak_i/ecall_i (exceptions), mret_i,
//           ext_i/soft_i/tcmp_i (masked irqs), mie_i (mstatus.MIE)
//  Outputs: take_o (something is accepted), is_mret_o, is_irq_o, cause_o (mcause value)
module trap_prio
    import trap_ctrl_pkg::*;
(
    input  logic        valid_i,
    input  logic        illegal_i,
    input  logic        ebreak_i,
    input  logic        ecall_i,
    input  logic        mret_i,
    input  logic        ext_i,
    input  logic        soft_i,
    input  logic        tcmp_i,
    input  logic        mie_i,
    output logic        take_o,
    output logic        is_mret_o,
    output logic        is_irq_o,
    output logic [31:0] cause_o
);

    logic exc;
    logic irq;

    assign exc       = valid_i & (illegal_i | ebreak_i | ecall_i);
    assign irq       = valid_i & mie_i & (ext_i | soft_i | tcmp_i);
    assign is_mret_o = valid_i & mret_i & ~exc;
    assign is_irq_o  = irq & ~exc & ~(valid_i & mret_i);
    assign take_o    = exc | is_mret_o | is_irq_o;
    // Exception causes are checked first, so the irq branches are only reached when no exception is set.
    assign cause_o   = illegal_i ? TRAP_CAUSE_ILLEGAL :
                       ebreak_i  ? TRAP_CAUSE_EBREAK  :
                       ecall_i   ? TRAP_CAUSE_ECALL   :
                       ext_i     ? TRAP_CAUSE_EXT     :
                       soft_i    ? TRAP_CAUSE_SOFT    : TRAP_CAUSE_TIMER;

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer saving/restoring mepc/mcause/mstatus and redirecting the pipeline.
//  Optional feature: TRAP_VECTORED_EN enables vectored mtvec mode for interrupts.
//  Ports:
//   clk, rst_n (async, active-low)
//   ex_trap_i/tcmp_trap_i/soft_trap_i : masked irq levels; mstatus_mie_i : global enable
//   mepc_i : current mepc; inst_valid_i/inst_pc_i : ID/EX instruction
//   ecall_i/ebreak_i/illegal_i/mret_i : decoded events qualified by inst_valid_i
//   trap_csr_we_o/addr_o/wdata_o, trap_csr_rdata_i : CSR trap channel (same-cycle read)
//   hold_o : pipeline stall; jump_o/jump_addr_o : one-cycle redirect
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter logic [31:0] RST_PC = 32'h0
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_trap_i,
    input  logic        tcmp_trap_i,
    input  logic        soft_trap_i,
    input  logic        mstatus_mie_i,
    input  logic [31:0] mepc_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_pc_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        illegal_i,
    input  logic        mret_i,
    output logic        trap_csr_we_o,
    output logic [11:0] trap_csr_addr_o,
    output logic [31:0] trap_csr_wdata_o,
    input  logic [31:0] trap_csr_rdata_i,
    output logic        hold_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] S_MEPC   = 3'd1;
    localparam logic [2:0] S_MCAUSE = 3'd2;
    localparam logic [2:0] S_MSTAT  = 3'd3;
    localparam logic [2:0] S_JUMP   = 3'd4;
    localparam logic [2:0] S_MRET   = 3'd5;

`ifdef TRAP_VECTORED_EN
    localparam bit VEC_EN = 1'b1;
`else
    localparam bit VEC_EN = 1'b0;
`endif

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] cause_q, cause_d;
    logic        mret_q, mret_d;
    logic        irq_q, irq_d;
    logic        take, is_mret, is_irq;
    logic [31:0] cause;
    logic [31:0] vec_off;

    trap_prio u_prio (
        .valid_i   (inst_valid_i),
        .illegal_i (illegal_i),
        .ebreak_i  (ebreak_i),
        .ecall_i   (ecall_i),
        .mret_i    (mret_i),
        .ext_i     (ex_trap_i),
        .soft_i    (soft_trap_i),
        .tcmp_i    (tcmp_trap_i),
        .mie_i     (mstatus_mie_i),
        .take_o    (take),
        .is_mret_o (is_mret),
        .is_irq_o  (is_irq),
        .cause_o   (cause)
    );

    // Vectored offset applies only to interrupts when mtvec.MODE reads as 01.
    assign vec_off = (VEC_EN && irq_q && trap_csr_rdata_i[1:0] == 2'b01) ? {cause_q[29:0], 2'b00} : 32'd0;

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        cause_d          = cause_q;
        mret_d           = mret_q;
        irq_d            = irq_q;
        trap_csr_we_o    = 1'b0;
        trap_csr_addr_o  = 12'h0;
        trap_csr_wdata_o = 32'h0;
        jump_o           = 1'b0;
        jump_addr_o      = RST_PC;
        hold_o           = 1'b1;
        case (state_q)
            IDLE: begin
                // Stall combinationally on the accept cycle so the instruction does not retire.
                hold_o = take & rst_n;
                if (take) begin
                    state_d = is_mret ? S_MRET : S_MEPC;
                    pc_d    = inst_pc_i;
                    cause_d = cause;
                    mret_d  = is_mret;
                    irq_d   = is_irq;
                end
            end
            S_MEPC: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MEPC;
                trap_csr_wdata_o = pc_q;
                state_d          = S_MCAUSE;
            end
            S_MCAUSE: begin
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MCAUSE;
                trap_csr_wdata_o = cause_q;
                state_d          = S_MSTAT;
            end
            S_MSTAT: begin
                // MPIE <- MIE, MIE <- 0
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = {trap_csr_rdata_i[31:8], trap_csr_rdata_i[3], trap_csr_rdata_i[6:4],
                                    1'b0, trap_csr_rdata_i[2:0]};
                state_d          = S_JUMP;
            end
            S_MRET: begin
                // MIE <- MPIE, MPIE <- 1
                trap_csr_we_o    = 1'b1;
                trap_csr_addr_o  = CSR_MSTATUS;
                trap_csr_wdata_o = {trap_csr_rdata_i[31:8], 1'b1, trap_csr_rdata_i[6:4],
                                    trap_csr_rdata_i[7], trap_csr_rdata_i[2:0]};
                state_d          = S_JUMP;
            end
            S_JUMP: begin
                trap_csr_addr_o = CSR_MTVEC;
                jump_o          = 1'b1;
                jump_addr_o     = mret_q ? mepc_i : {trap_csr_rdata_i[31:2], 2'b00} + vec_off;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= 32'h0;
            cause_q <= 32'h0;
            mret_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cause_q <= cause_d;
            mret_q  <= mret_d;
            irq_q   <= irq_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: self-checking bench for trap_ctrl with a behavioural CSR file and trap model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_trap, tcmp_trap, soft_trap, mie;
    logic        inst_valid, ecall, ebreak, illegal, mret;
    logic [31:0] inst_pc, mepc_q;
    logic        we, hold, jump;
    logic [11:0] addr;
    logic [31:0] wdata, rdata, jump_addr;
    logic [31:0] csr_mepc, csr_mcause, csr_mstatus, csr_mtvec;
    int          total = 0;
    int          bad = 0;

    // flags: {valid, illegal, ebreak, ecall, mret, ext, soft, tcmp, mie}
    typedef struct {
        logic [8:0]  f;
        logic [31:0] pc;
        logic        take;
        logic        mr;
        logic [31:0] cause;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    assign mie    = csr_mstatus[3];
    assign mepc_q = csr_mepc;
    assign rdata  = addr == 12'h300 ? csr_mstatus : addr == 12'h305 ? csr_mtvec :
                    addr == 12'h341 ? csr_mepc : addr == 12'h342 ? csr_mcause : 32'h0;

    trap_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_trap_i        (ex_trap),
        .tcmp_trap_i      (tcmp_trap),
        .soft_trap_i      (soft_trap),
        .mstatus_mie_i    (mie),
        .mepc_i           (mepc_q),
        .inst_valid_i     (inst_valid),
        .inst_pc_i        (inst_pc),
        .ecall_i          (ecall),
        .ebreak_i         (ebreak),
        .illegal_i        (illegal),
        .mret_i           (mret),
        .trap_csr_we_o    (we),
        .trap_csr_addr_o  (addr),
        .trap_csr_wdata_o (wdata),
        .trap_csr_rdata_i (rdata),
        .hold_o           (hold),
        .jump_o           (jump),
        .jump_addr_o      (jump_addr)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // One clock: CSR file commits the write presented before the edge.
    task automatic tick();
        logic        w;
        logic [11:0] a;
        logic [31:0] d;
        w = we;
        a = addr;
        d = wdata;
        @(posedge clk);
        if (w && rst_n) begin
            if (a == 12'h341) csr_mepc = d;
            else if (a == 12'h342) csr_mcause = d;
            else if (a == 12'h300) csr_mstatus = d;
        end
        #1;
    endtask

    task automatic clr();
        {inst_valid, illegal, ebreak, ecall, mret, ex_trap, soft_trap, tcmp_trap} = 8'h0;
        inst_pc = 32'h0;
    endtask

    task automatic noise();
        inst_valid = 1'($urandom_range(0, 1));
        illegal    = ($urandom_range(0, 3) == 0);
        ebreak     = ($urandom_range(0, 3) == 0);
        ecall      = ($urandom_range(0, 3) == 0);
        mret       = ($urandom_range(0, 3) == 0);
        ex_trap    = 1'($urandom_range(0, 1));
        soft_trap  = 1'($urandom_range(0, 1));
        tcmp_trap  = 1'($urandom_range(0, 1));
        inst_pc    = $urandom;
    endtask

    task automatic apply(input vec_t v);
        {inst_valid, illegal, ebreak, ecall, mret, ex_trap, soft_trap, tcmp_trap} = v.f[8:1];
        csr_mstatus[3] = v.f[0];
        inst_pc        = v.pc;
    endtask

    // Reference decision: first matching candidate in architectural priority order.
    function automatic vec_t model(input vec_t v);
        logic [31:0] causes[7];
        logic        hit[7];
        vec_t        r;
        causes = '{32'h2, 32'h3, 32'hB, 32'h0, 32'h8000000B, 32'h80000003, 32'h80000007};
        hit    = '{v.f[7], v.f[6], v.f[5], v.f[4], v.f[3] & v.f[0], v.f[2] & v.f[0], v.f[1] & v.f[0]};
        r       = v;
        r.take  = 1'b0;
        r.mr    = 1'b0;
        r.cause = 32'h0;
        if (v.f[8])
            for (int i = 6; i >= 0; i--)
                if (hit[i]) begin
                    r.take  = 1'b1;
                    r.mr    = (i == 3);
                    r.cause = causes[i];
                end
        return r;
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] tv, input logic [31:0] c);
        logic [31:0] base;
        base = tv & ~32'h3;
`ifdef TRAP_VECTORED_EN
        if (tv[1:0] == 2'b01 && c[31]) return base + 4 * (c & 32'h7FFF_FFFF);
`endif
        return base;
    endfunction

    task automatic run_txn(input vec_t v, output logic [31:0] jaddr);
        logic [31:0] ms0, mepc0, mc0, ems;
        int          n;
        apply(v);
        ms0   = csr_mstatus;
        mepc0 = csr_mepc;
        mc0   = csr_mcause;
        jaddr = 32'h0;
        #1;
        chk("accept_hold", 32'(hold), 32'(v.take));
        tick();
        if (v.take) noise(); else clr();
        #1;
        n = 1;
        if (v.take) begin
            while (!jump && n < 8) begin
                chk("seq_hold", 32'(hold), 32'h1);
                tick();
                noise();
                #1;
                n++;
            end
            chk("jump_latency", 32'(n), v.mr ? 32'd2 : 32'd4);
            chk("jump_hold", 32'(hold), 32'h1);
            jaddr = jump_addr;
            chk("jump_addr", jump_addr, v.mr ? mepc0 : model_target(csr_mtvec, v.cause));
            tick();
            clr();
            #1;
        end
        chk("idle_hold", 32'(hold), 32'h0);
        if (v.take && !v.mr) ems = (ms0 & ~32'h88) | (32'(ms0[3]) << 7);
        else if (v.take) ems = (ms0 & ~32'h88) | 32'h80 | (32'(ms0[7]) << 3);
        else ems = ms0;
        chk("mstatus", csr_mstatus, ems);
        chk("mepc", csr_mepc, (v.take && !v.mr) ? v.pc : mepc0);
        chk("mcause", csr_mcause, (v.take && !v.mr) ? v.cause : mc0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ja, mc_keep;
        vec_t        v;
        tbl[0]  = '{9'b1_0000_1001, 32'h2000, 1'b1, 1'b0, 32'h8000000B};
        tbl[1]  = '{9'b1_0010_0000, 32'h0040, 1'b1, 1'b0, 32'h0000000B};
        tbl[2]  = '{9'b1_0100_0001, 32'h0044, 1'b1, 1'b0, 32'h00000003};
        tbl[3]  = '{9'b1_1110_0000, 32'h0048, 1'b1, 1'b0, 32'h00000002};
        tbl[4]  = '{9'b1_0001_0000, 32'h004C, 1'b1, 1'b1, 32'h0};
        tbl[5]  = '{9'b1_0001_1001, 32'h0050, 1'b1, 1'b1, 32'h0};
        tbl[6]  = '{9'b1_0011_0000, 32'h0054, 1'b1, 1'b0, 32'h0000000B};
        tbl[7]  = '{9'b1_0000_1111, 32'h0058, 1'b1, 1'b0, 32'h8000000B};
        tbl[8]  = '{9'b1_0000_0111, 32'h005C, 1'b1, 1'b0, 32'h80000003};
        tbl[9]  = '{9'b1_0000_0011, 32'h0060, 1'b1, 1'b0, 32'h80000007};
        tbl[10] = '{9'b1_0000_1000, 32'h0064, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{9'b0_0010_0000, 32'h0068, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{9'b0_0000_1001, 32'h006C, 1'b0, 1'b0, 32'h0};
        tbl[13] = '{9'b1_0100_1001, 32'h0070, 1'b1, 1'b0, 32'h00000003};

        rst_n       = 1'b0;
        clr();
        csr_mepc    = 32'h0;
        csr_mcause  = 32'h0;
        csr_mstatus = 32'h0;
        csr_mtvec   = 32'h100;
        tick();
        tick();
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_hold", 32'(hold), 32'h0);
        chk("rst_jump", 32'(jump), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_jump_addr", jump_addr, 32'h0);
        rst_n = 1'b1;
        #1;

        // Directed scenarios
        run_txn('{9'b1_0000_1001, 32'h2000, 1'b1, 1'b0, 32'h8000000B}, ja);
        chk("t1_jump", ja, 32'h100);
        chk("t1_mstatus", csr_mstatus, 32'h80);
        run_txn('{9'b1_0001_0000, 32'h0, 1'b1, 1'b1, 32'h0}, ja);
        chk("t3_jump", ja, 32'h2000);
        chk("t3_mstatus", csr_mstatus, 32'h88);
        run_txn('{9'b1_0010_0000, 32'h40, 1'b1, 1'b0, 32'hB}, ja);
        chk("t2_jump", ja, 32'h100);
        run_txn('{9'b1_0000_1111, 32'h80, 1'b1, 1'b0, 32'h8000000B}, ja);
        for (int i = 0; i < 3; i++) begin
            apply('{9'b1_0000_0010, 32'h84, 1'b0, 1'b0, 32'h0});
            #1;
            chk("t4_no_nest", 32'(hold), 32'h0);
            tick();
        end
        run_txn('{9'b1_0001_0010, 32'h88, 1'b1, 1'b1, 32'h0}, ja);
        chk("t4_ret_addr", ja, 32'h80);
        run_txn('{9'b1_0000_0011, 32'h8C, 1'b1, 1'b0, 32'h80000007}, ja);

        // Reset in S_MCAUSE
        mc_keep = csr_mcause;
        apply('{9'b1_0000_1001, 32'h3000, 1'b0, 1'b0, 32'h0});
        #1;
        tick();
        clr();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_we", 32'(we), 32'h0);
        chk("t5_hold", 32'(hold), 32'h0);
        chk("t5_addr", 32'(addr), 32'h0);
        chk("t5_wdata", wdata, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_idle_hold", 32'(hold), 32'h0);
        chk("t5_mepc_kept", csr_mepc, 32'h3000);
        chk("t5_mcause_kept", csr_mcause, mc_keep);
        run_txn('{9'b1_0010_0000, 32'h90, 1'b1, 1'b0, 32'hB}, ja);

        // Vectored mtvec with timer irq
        csr_mtvec = 32'h101;
        run_txn('{9'b1_0000_0011, 32'h94, 1'b1, 1'b0, 32'h80000007}, ja);
`ifdef TRAP_VECTORED_EN
        chk("t6_vec_jump", ja, 32'h11C);
`else
        chk("t6_vec_jump", ja, 32'h100);
`endif
        run_txn('{9'b1_0010_0001, 32'h98, 1'b1, 1'b0, 32'hB}, ja);
        chk("t6_exc_base", ja, 32'h100);

        // Table
        csr_mtvec = 32'h100;
        for (int i = 0; i < 14; i++) run_txn(tbl[i], ja);

        // Randomized against the reference model
        for (int i = 0; i < 300; i++) begin
            csr_mtvec   = $urandom;
            csr_mstatus = $urandom;
            csr_mepc    = $urandom;
            v.f  = {($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
            v.pc = $urandom;
            v = model(v);
            run_txn(v, ja);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
